// File: rtl/sdram_bist.sv
// sdram_bist: SDRAM built-in self-test engine on the controller's req/ack/valid user port.
// Each pass writes a pattern over [BASE_ADDR, BASE_ADDR+NUM_WORDS) and then reads it back,
// comparing every word against a regenerated copy. Odd passes use the inverted pattern.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   start, mode[1:0], loop       test control (mode sampled on start only)
//   mem_addr/data/we/req         registered request to the controller
//   mem_ack, mem_valid, mem_q    controller handshake and read data
//   busy, done, err, timeout     status (err and timeout are sticky)
//   err_count, pass_count        saturating mismatch count, wrapping pass count
//   fail_addr/exp/act            first-failure capture, only when ERR_CAPTURE_EN is defined;
//                                otherwise tied to 0
module sdram_bist #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned NUM_WORDS   = 65536,
  parameter int unsigned TIMEOUT     = 1023,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              loop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [15:0]       pass_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act
);
  localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(BASE_ADDR + NUM_WORDS - 1);
  localparam logic [31:0]       LfsrSeed  = 32'hACE1_0001;
  localparam logic [31:0]       LfsrTaps  = 32'h8020_0003;
  localparam int unsigned       WaitW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0]  WaitLast  = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StRwait, StDone} state_e;

  state_e            state_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] walk_q;  // walking-one generator, rotates once per accepted word
  logic [31:0]       lfsr_q;
  logic [WaitW-1:0]  wait_q;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LfsrTaps) : (s >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] w, input logic [31:0] l,
                                                input logic inv);
    logic [15:0]       a16;
    logic [31:0]       aw;
    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] rep_a;
    logic [DATA_W-1:0] rep_l;
    a16 = 16'(a);
    aw  = {~a16, a16};
    for (int b = 0; b < int'(DATA_W); b++) begin
      rep_a[b] = aw[b % 32];
      rep_l[b] = l[b % 32];
    end
    case (m)
      2'd0:    p = rep_a;
      2'd1:    p = w;
      2'd2:    p = (a[0] ^ FirstAddr[0]) ? {(DATA_W/2){2'b10}} : {(DATA_W/2){2'b01}};
      default: p = rep_l;
    endcase
    return inv ? ~p : p;
  endfunction

  logic [ADDR_W-1:0] nxt_addr;
  logic [DATA_W-1:0] nxt_walk, nxt_data, first_data, next_pass_data;
  logic [31:0]       nxt_lfsr;
  logic last_word, start_ok, req_rise, wr_acc, rd_acc, rd_take, rd_bad, stop;
  logic waiting, tmo, pass_end, advance, finish;

  always_comb begin
    nxt_addr       = mem_addr + 1'b1;
    nxt_walk       = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
    nxt_lfsr       = lfsr_step(lfsr_q);
    nxt_data       = pattern(mode_q, nxt_addr, nxt_walk, nxt_lfsr, pass_count[0]);
    first_data     = pattern(mode_q, FirstAddr, DATA_W'(1), LfsrSeed, pass_count[0]);
    next_pass_data = pattern(mode_q, FirstAddr, DATA_W'(1), LfsrSeed, ~pass_count[0]);
    last_word      = (mem_addr == LastAddr);
    start_ok       = start && (state_q == StIdle || state_q == StDone);
    req_rise       = (state_q == StWrite || state_q == StRead) && !mem_req;
    wr_acc         = (state_q == StWrite) && mem_req && mem_ack;
    rd_acc         = (state_q == StRead) && mem_req && mem_ack;
    // Read data may arrive together with the ack; it is consumed in that cycle.
    rd_take        = mem_valid && (rd_acc || state_q == StRwait);
    rd_bad         = rd_take && (mem_q != mem_data);
    stop           = rd_bad && STOP_ON_ERR;
    waiting        = ((state_q == StWrite || state_q == StRead) && mem_req && !mem_ack) ||
                     (state_q == StRwait && !mem_valid);
    tmo            = waiting && (wait_q == WaitLast);
    pass_end       = rd_take && last_word && !stop;
    advance        = (wr_acc && !last_word) || (rd_take && !last_word && !stop);
    finish         = tmo || stop || (pass_end && !loop);
  end

  // Later statements take priority; finish overrides any transition decided above it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      walk_q     <= '0;
      lfsr_q     <= '0;
      wait_q     <= '0;
      mem_addr   <= FirstAddr;
      mem_data   <= '0;
      mem_we     <= 1'b0;
      mem_req    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
      err_count  <= '0;
      pass_count <= '0;
    end else begin
      if (start_ok) begin
        state_q    <= StWrite;
        mode_q     <= mode;
        busy       <= 1'b1;
        done       <= 1'b0;
        err        <= 1'b0;
        timeout    <= 1'b0;
        err_count  <= '0;
        pass_count <= '0;
        mem_we     <= 1'b1;
        mem_req    <= 1'b0;
        mem_addr   <= FirstAddr;
        walk_q     <= DATA_W'(1);
        lfsr_q     <= LfsrSeed;
        mem_data   <= pattern(mode, FirstAddr, DATA_W'(1), LfsrSeed, 1'b0);
      end
      // Wait counter restarts with every new request and runs until ack/valid.
      if (req_rise) begin
        mem_req <= 1'b1;
        wait_q  <= '0;
      end else if (waiting) begin
        wait_q <= wait_q + 1'b1;
      end
      if (wr_acc || rd_acc) mem_req <= 1'b0;
      if (rd_acc && !mem_valid) state_q <= StRwait;
      if (rd_bad) begin
        err <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
      end
      if (advance) begin
        mem_addr <= nxt_addr;
        walk_q   <= nxt_walk;
        lfsr_q   <= nxt_lfsr;
        mem_data <= nxt_data;
        if (state_q != StWrite) state_q <= StRead;
      end
      if (wr_acc && last_word) begin
        state_q  <= StRead;
        mem_we   <= 1'b0;
        mem_addr <= FirstAddr;
        walk_q   <= DATA_W'(1);
        lfsr_q   <= LfsrSeed;
        mem_data <= first_data;
      end
      if (pass_end) begin
        pass_count <= pass_count + 1'b1;
        if (loop) begin
          state_q  <= StWrite;
          mem_we   <= 1'b1;
          mem_addr <= FirstAddr;
          walk_q   <= DATA_W'(1);
          lfsr_q   <= LfsrSeed;
          mem_data <= next_pass_data;
        end
      end
      if (tmo) timeout <= 1'b1;
      if (finish) begin
        state_q <= StDone;
        busy    <= 1'b0;
        done    <= 1'b1;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
    end
  end

`ifdef ERR_CAPTURE_EN
  // err is still 0 on the first mismatch of a test, which gates the capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else if (start_ok) begin
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else if (rd_bad && !err) begin
      fail_addr <= mem_addr;
      fail_exp  <= mem_data;
      fail_act  <= mem_q;
    end
  end
`else
  assign fail_addr = '0;
  assign fail_exp  = '0;
  assign fail_act  = '0;
`endif

endmodule
